// File: rtl/lsu_ram_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ram_ctrl
//
// Load/store controller between the CPU MEM stage and a word-wide single-port
// data RAM with no byte lanes. Accepts one byte/half/word access per request,
// checks funct3, alignment and address range, sign/zero-extends loads and
// performs read-modify-write for SB/SH.
//
// Handshake: a request transfers on the rising clock edge where
// req_valid && req_ready. req_ready is registered and high only while idle;
// every request field is captured at that edge and later input changes are
// ignored. The response side has no ready: resp_valid is a one-cycle pulse
// that the consumer must take, with resp_rdata/resp_err qualified by it.
//
// Ports
//   clock, rst_n        : clock (posedge), asynchronous active-low reset
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RISC-V load/store funct3
//   req_addr            : byte address
//   req_wdata           : store data (low bits for SB/SH)
//   resp_valid          : one-cycle response pulse
//   resp_rdata          : load result, 0 for stores and errors
//   resp_err            : misaligned / illegal funct3 / out of range
//   ram_addr            : word index to the RAM
//   ram_we              : RAM write enable (sampled by the RAM on negedge)
//   ram_wdata           : RAM write data
//   ram_rdata           : RAM read data, combinational from ram_addr
//   dbg_state           : current FSM state (IDLE=0 ACCESS=1 WRITE=2 RESP=3)
// -----------------------------------------------------------------------------
module lsu_ram_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e         state_q;
  logic           req_ready_q;
  logic           resp_valid_q;
  logic           resp_err_q;
  logic [31:0]    resp_rdata_q;
  logic [AW-1:0]  ram_addr_q;
  logic           ram_we_q;
  logic [31:0]    ram_wdata_q;
  logic           we_q;
  logic [2:0]     funct3_q;
  logic [1:0]     lane_q;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, used only at the accept edge)
  // ---------------------------------------------------------------------------
  logic [29:0] word_idx;
  logic        out_of_range;
  logic        bad_funct3;
  logic        misaligned;
  logic        req_err;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign word_idx     = 30'((req_addr - BASE_ADDR) >> 2);
  assign out_of_range = ({2'b00, word_idx} >= DEPTH);

  always_comb begin
    bad_funct3 = 1'b0;
    if (req_we) begin
      bad_funct3 = (req_funct3 > 3'b010);
    end else begin
      bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err    = out_of_range || bad_funct3 || misaligned;

  // ---------------------------------------------------------------------------
  // Load extraction and sub-word store merge from the RAM word of the latched
  // access. For SB/SH the low bits of ram_wdata_q still hold the store data
  // captured at accept; they are overwritten with the merged word afterwards.
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  always_comb begin
    byte_v = ram_rdata[{lane_q, 3'b000} +: 8];
    half_v = ram_rdata[{lane_q[1], 4'b0000} +: 16];
    load_d = ram_rdata;
    case (funct3_q)
      3'b000:  load_d = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_d = {{16{half_v[15]}}, half_v};
      3'b100:  load_d = {24'h0, byte_v};
      3'b101:  load_d = {16'h0, half_v};
      default: load_d = ram_rdata;
    endcase
  end

  always_comb begin
    merge_d = ram_rdata;
    case (funct3_q[1:0])
      2'b00:   merge_d[{lane_q, 3'b000} +: 8]     = ram_wdata_q[7:0];
      2'b01:   merge_d[{lane_q[1], 4'b0000} +: 16] = ram_wdata_q[15:0];
      default: merge_d = ram_wdata_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs. ram_we is a flop cleared by the asynchronous
  // reset, so it is stable across the RAM's negedge and drops with reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= 32'h0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            lane_q      <= req_addr[1:0];
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q     <= S_ACCESS;
              ram_addr_q  <= word_idx[AW-1:0];
              ram_wdata_q <= req_wdata;
              // SW writes straight through during ACCESS.
              ram_we_q    <= req_we && (req_funct3 == 3'b010);
            end
          end else begin
            // First edge after reset release also lands here.
            req_ready_q <= 1'b1;
          end
        end

        S_ACCESS: begin
          if (we_q && (funct3_q[1:0] != 2'b10)) begin
            ram_wdata_q <= merge_d;
            ram_we_q    <= 1'b1;
            state_q     <= S_WRITE;
          end else begin
            ram_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'h0 : load_d;
            state_q      <= S_RESP;
          end
        end

        S_WRITE: begin
          ram_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          state_q      <= S_RESP;
        end

        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign dbg_state  = state_q;

endmodule
